// File: rtl/fir_bank_mac.sv
// fir_bank_mac: multi-channel FIR filter bank.
// NUM_CH filters share one NUM_TAPS-deep circular sample history. Each accepted
// sample starts a serial sweep of one tap per cycle. All channels accumulate in
// parallel. The sweep ends with one scaled, saturated result per channel.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   sample_in    signed input sample
//   sample_valid sample_in is valid
//   sample_ready block can take a sample this cycle (IDLE)
//   flush        synchronous clear of history and abort of any sweep
//   coef_addr    tap index to the external synchronous coefficient ROM
//   coef_data    per-channel coefficients, valid one cycle after coef_addr
//   y_out        per-channel results, channel c at [c*OUT_W +: OUT_W]
//   y_valid      one-cycle strobe marking a y_out update
//   busy         sweep in progress
module fir_bank_mac #(
    parameter int unsigned NUM_CH      = 13,
    parameter int unsigned NUM_TAPS    = 174,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned COEF_W      = 8,
    parameter int unsigned COEF_SIGNED = 0,
    parameter int unsigned ACC_W       = 46,
    parameter int unsigned SHIFT       = 12,
    parameter int unsigned OUT_W       = 34
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic signed [DATA_W-1:0]      sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          flush,
    output logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic [NUM_CH*COEF_W-1:0]      coef_data,
    output logic [NUM_CH*OUT_W-1:0]       y_out,
    output logic                          y_valid,
    output logic                          busy
);

    localparam int unsigned ADDR_W = $clog2(NUM_TAPS);
    localparam int unsigned CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int unsigned PROD_W = DATA_W + COEF_W + 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nx;

    logic signed [DATA_W-1:0] hist [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc    [NUM_CH];
    logic signed [ACC_W-1:0]  acc_nx [NUM_CH];
    logic signed [DATA_W-1:0] hist_q;
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        base;
    logic [ADDR_W-1:0]        rd_idx;
    logic [CNT_W-1:0]         cnt;
    logic [NUM_CH*OUT_W-1:0]  y_nx;
    logic                     accept;
    logic                     last_tap;

    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = (state == IDLE) && sample_valid && !flush;
    // cnt runs 0..NUM_TAPS over the MAC cycles; the final count absorbs the last tap.
    assign last_tap     = (state == MAC) && (cnt == CNT_W'(NUM_TAPS));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_valid) state_nx = MAC;
            MAC:     if (cnt == CNT_W'(NUM_TAPS)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    // Tap cnt sits cnt places behind the newest sample, modulo the buffer depth.
    always_comb begin
        if (32'(cnt) <= 32'(base)) begin
            rd_idx = ADDR_W'(32'(base) - 32'(cnt));
        end else begin
            rd_idx = ADDR_W'(32'(base) + NUM_TAPS - 32'(cnt));
        end
    end

    // One tap per channel: extend the coefficient by one bit (sign or zero),
    // take the full-width product, sign-extend into the accumulator, and form
    // the scaled, clamped result from the post-add value so y_out can be
    // registered on the same edge that absorbs the last tap.
    always_comb begin
        y_nx = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            logic [COEF_W-1:0]        raw;
            logic signed [COEF_W:0]   cext;
            logic signed [PROD_W-1:0] prod;
            logic signed [ACC_W-1:0]  s;
            raw  = coef_data[c*COEF_W +: COEF_W];
            cext = {(COEF_SIGNED != 0) ? raw[COEF_W-1] : 1'b0, raw};
            prod = PROD_W'(hist_q) * PROD_W'(cext);
            acc_nx[c] = acc[c] + ACC_W'(prod);
            s = acc_nx[c] >>> SHIFT;
            if (s > OUT_MAX) begin
                y_nx[c*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
            end else if (s < OUT_MIN) begin
                y_nx[c*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
            end else begin
                y_nx[c*OUT_W +: OUT_W] = s[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) hist[i] <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
            wr_ptr    <= '0;
            base      <= '0;
            cnt       <= '0;
            coef_addr <= '0;
            hist_q    <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) hist[i] <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            coef_addr <= '0;
            y_valid   <= 1'b0;
        end else begin
            y_valid <= last_tap;
            if (accept) begin
                hist[wr_ptr] <= sample_in;
                base         <= wr_ptr;
                wr_ptr       <= (wr_ptr == ADDR_W'(NUM_TAPS - 1)) ? '0 : wr_ptr + ADDR_W'(1);
                for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
                cnt          <= '0;
                coef_addr    <= '0;
            end
            if (state == MAC) begin
                cnt <= cnt + CNT_W'(1);
                if (coef_addr != ADDR_W'(NUM_TAPS - 1)) begin
                    coef_addr <= coef_addr + ADDR_W'(1);
                end
                // Registered together with coef_addr so it meets coef_data a cycle later.
                hist_q <= hist[rd_idx];
                if (cnt != '0) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= acc_nx[i];
                end
                if (last_tap) begin
                    y_out <= y_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_bank_mac.sv
// Self-checking bench for fir_bank_mac.
// Instance a: 2 channels, 4 taps, signed coefficients, SHIFT 2, OUT_W 20.
// Instance b: 3 channels, 4 taps, unsigned coefficients, SHIFT 2, OUT_W 8.
// A software model of each history buffer predicts the results at accept time.
// Those predictions are queued and compared when y_valid fires.
module tb_fir_bank_mac;

    typedef struct packed {
        logic [2:0][63:0] y;
        int               cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] sin_a, sin_b;
    logic        sv_a, sv_b, flush_a, flush_b;
    logic        rdy_a, rdy_b, yv_a, yv_b, busy_a, busy_b;
    logic [1:0]  caddr_a, caddr_b;
    logic [15:0] cdata_a;
    logic [23:0] cdata_b;
    logic [39:0] y_a;
    logic [23:0] y_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // coef[dut][channel][tap]
    int coef [2][3][4] = '{
        '{'{8, 4, -4, 12}, '{1, 1, 1, 1}, '{0, 0, 0, 0}},
        '{'{1, 0, 0, 0},   '{8, 0, 0, 0}, '{255, 0, 0, 0}}
    };
    longint hist [2][4];
    exp_t   q_a[$];
    exp_t   q_b[$];
    longint last_a0 = 0;

    fir_bank_mac #(
        .NUM_CH(2), .NUM_TAPS(4), .DATA_W(32), .COEF_W(8), .COEF_SIGNED(1),
        .ACC_W(46), .SHIFT(2), .OUT_W(20)
    ) dut_a (
        .clk(clk), .resetn(resetn), .sample_in(sin_a), .sample_valid(sv_a),
        .sample_ready(rdy_a), .flush(flush_a), .coef_addr(caddr_a),
        .coef_data(cdata_a), .y_out(y_a), .y_valid(yv_a), .busy(busy_a)
    );

    fir_bank_mac #(
        .NUM_CH(3), .NUM_TAPS(4), .DATA_W(32), .COEF_W(8), .COEF_SIGNED(0),
        .ACC_W(46), .SHIFT(2), .OUT_W(8)
    ) dut_b (
        .clk(clk), .resetn(resetn), .sample_in(sin_b), .sample_valid(sv_b),
        .sample_ready(rdy_b), .flush(flush_b), .coef_addr(caddr_b),
        .coef_data(cdata_b), .y_out(y_b), .y_valid(yv_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous coefficient ROMs: data follows the address by one cycle.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) cdata_a[c*8 +: 8] <= 8'(coef[0][c][caddr_a]);
        for (int c = 0; c < 3; c++) cdata_b[c*8 +: 8] <= 8'(coef[1][c][caddr_b]);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_ch(input int sel, input int c);
        longint acc, s, mx, mn;
        int     ow;
        ow  = (sel == 0) ? 20 : 8;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += hist[sel][k] * longint'(coef[sel][c][k]);
        s  = acc >>> 2;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -(longint'(1) <<< (ow - 1));
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

    // Cycle 0 is the IDLE cycle whose closing edge accepts the sample.
    task automatic accept_model(input int sel, input logic signed [31:0] x);
        exp_t e;
        for (int k = 3; k > 0; k--) hist[sel][k] = hist[sel][k-1];
        hist[sel][0] = longint'(x);
        e.cyc = cyc - 1;
        for (int c = 0; c < 3; c++) e.y[c] = model_ch(sel, c);
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic clear_model(input int sel);
        for (int k = 0; k < 4; k++) hist[sel][k] = 0;
        if (sel == 0) q_a.delete();
        else          q_b.delete();
    endtask

    task automatic send(input int sel, input logic signed [31:0] x);
        int n = 0;
        @(negedge clk);
        while ((sel == 0) ? !rdy_a : !rdy_b) begin
            n++;
            if (n > 50) begin
                check("ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        if (sel == 0) begin sin_a = x; sv_a = 1'b1; end
        else          begin sin_b = x; sv_b = 1'b1; end
        @(posedge clk);
        #1;
        accept_model(sel, x);
        sv_a = 1'b0;
        sv_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", q_a.size() + q_b.size(), 0);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (resetn && yv_a) begin
            if (q_a.size() == 0) begin
                check("a_spurious_valid", 1, 0);
            end else begin
                e = q_a.pop_front();
                for (int c = 0; c < 2; c++)
                    check($sformatf("a_y%0d", c), longint'($signed(y_a[c*20 +: 20])), longint'($signed(e.y[c])));
                check("a_latency", cyc - e.cyc, 6);
                last_a0 = longint'($signed(e.y[0]));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (resetn && yv_b) begin
            if (q_b.size() == 0) begin
                check("b_spurious_valid", 1, 0);
            end else begin
                e = q_b.pop_front();
                for (int c = 0; c < 3; c++)
                    check($sformatf("b_y%0d", c), longint'($signed(y_b[c*8 +: 8])), longint'($signed(e.y[c])));
                check("b_latency", cyc - e.cyc, 6);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        logic acc_now;
        resetn = 1'b0;
        sin_a = '0; sin_b = '0; sv_a = 1'b0; sv_b = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        clear_model(0);
        clear_model(1);
        repeat (3) @(negedge clk);
        check("rst_y_valid", yv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", rdy_a, 1);
        check("rst_y_out", y_a, 0);
        check("rst_coef_addr", caddr_a, 0);
        check("rst_b_y_out", y_b, 0);
        resetn = 1'b1;

        // Impulse response: ch0 2000,1000,-1000,3000,0 and ch1 250 x4 then 0.
        send(0, 1000);
        repeat (4) send(0, 0);
        drain();

        // Ten samples through a four-deep history exercises pointer wrap.
        for (int i = 0; i < 10; i++) send(0, 32'(i * 1234 - 5000));
        drain();

        // Backpressure: a new sample every cycle, only IDLE cycles accept.
        last = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sin_a   = 32'($signed($urandom) >>> 11);
            sv_a    = 1'b1;
            acc_now = rdy_a;
            @(posedge clk);
            #1;
            if (acc_now) begin
                accept_model(0, sin_a);
                if (last >= 0) check("bp_interval", cyc - last, 7);
                last = cyc;
                check("bp_ready_low", rdy_a, 0);
            end
        end
        sv_a = 1'b0;
        drain();

        // Flush mid-sweep: no output from the aborted sweep, y_out held.
        send(0, 555);
        repeat (3) @(negedge clk);
        flush_a = 1'b1;
        @(posedge clk);
        #1;
        flush_a = 1'b0;
        clear_model(0);
        check("flush_busy", busy_a, 0);
        check("flush_keep_y", longint'($signed(y_a[19:0])), last_a0);
        repeat (10) @(negedge clk);
        // Flush wins over a simultaneous accept.
        @(negedge clk);
        sin_a = 32'd42; sv_a = 1'b1; flush_a = 1'b1;
        @(posedge clk);
        #1;
        sv_a = 1'b0; flush_a = 1'b0;
        check("flush_drop_busy", busy_a, 0);
        send(0, 1000);
        drain();

        // Unsigned coefficients, floor and saturation on the narrow instance.
        send(1, -1);
        send(1, 1000);
        send(1, -1000);
        send(1, 4);
        send(1, 1);
        drain();

        // Reset mid-sweep discards both sweeps.
        send(0, 777);
        send(1, 5);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        clear_model(0);
        clear_model(1);
        check("midrst_y_valid", yv_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_ready", rdy_a, 1);
        check("midrst_y_out", y_a, 0);
        check("midrst_b_busy", busy_b, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        send(0, 1000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
